cpu_ctrl_fsm: RTL and testbench
===============================

// Module: cpu_ctrl_fsm
// PURPOSE
// Hardwired control unit for the 8-bit CPU. It sequences the datapath through fetch, decode and execute.
// It drives every register-load, bus-enable and memory strobe that top shows on LEDs.
// It also supplies run/single-step control so a board user can step the CPU one instruction at a time.
// PARAMETERS
// IR_W     8  instruction register width; opcode = ir[3:0], valid only when ir[7:4]==0
// ST_W     6  state register width (39 states used)
// PORTS
// clk        in   1     system clock (post-divider CPU clock)
// rst        in   1     synchronous reset, active-high
// ir         in   IR_W  instruction register contents
// z          in   1     zero flag from datapath
// run_mode   in   1     1=free-run, 0=single-step
// step       in   1     step request (level from key/switch; edge-detected internally)
// read,write out  1     memory strobes
// arload,arinc,pcinc,pcload,drload,trload,irload,rload,acload,zload  out 1  register controls
// pcbus,drhbus,drlbus,trbus,rbus,acbus,membus,busmem  out 1  bus drivers
// alu_op     out  3     000 ADD,001 SUB,010 INAC,011 CLAC(result 0),100 AND,101 OR,110 XOR,111 NOT
// state_code out  ST_W  current state (for cpustate display)
// instr_done out  1     high during final state of each instruction
// BEHAVIOUR
// - Moore FSM: all outputs decode combinationally from the state register only. alu_op=000 when not an ALU state.
// - Codes: WAIT0 FETCH1-3=1-3 NOP1=4 LDAC1-5=5-9 STAC1-5=10-14 MVAC1=15 MOVR1=16 JUMP1-3=17-19.
// - Codes cont.: JMPZY1-3=20-22 JMPZN1-2=23-24 JPNZY1-3=25-27 JPNZN1-2=28-29.
// - Codes cont.: ADD..NOT=30-37 (opcode order) DEC=38. Codes 39-63 are illegal: outputs 0, next state WAIT.
// - Reset: rst=1 at edge -> state WAIT, step_q=0. All controls are 0 in WAIT. Reset mid-instruction aborts it.
// - WAIT: go to FETCH1 if run_mode=1 or step rise (step & ~step_q). Otherwise stay in WAIT.
// - FETCH1: pcbus,arload.
// - FETCH2: read,membus,drload,pcinc.
// - FETCH3: irload (IR<=DR direct path),pcbus,arload.
// - DEC: no controls. Branch on ir. Opcodes 0-7: NOP,LDAC,STAC,MVAC,MOVR,JUMP,JMPZ,JPNZ. Opcodes 8-F: ADD,SUB,INAC,CLAC,AND,OR,XOR,NOT.
// - DEC: ir[7:4]!=0 -> NOP1. JMPZ goes to Y path if z=1, else N path; JPNZ goes to Y path if z=0.
// - LDAC1/STAC1: read,membus,drload,pcinc,arinc.
// - LDAC2/STAC2: read,membus,drload,trload,pcinc.
// - LDAC3/STAC3: drhbus,trbus,arload.
// - LDAC4: read,membus,drload. LDAC5: drlbus,acload.
// - STAC4: acbus,drload. STAC5: drlbus,busmem,write.
// - MVAC1: acbus,rload. MOVR1: rbus,acload.
// - JUMP1/JxxY1: read,membus,drload,arinc.
// - JUMP2/JxxY2: read,membus,drload,trload.
// - JUMP3/JxxY3: drhbus,trbus,pcload.
// - JxxN1, JxxN2: pcinc (skip the 2-byte address).
// - ADD,SUB,AND,OR,XOR: rbus,acload,zload + alu_op. INAC,CLAC,NOT: acload,zload + alu_op (no bus).
// - Last state of each instruction: instr_done=1. Next state FETCH1 if run_mode=1, else WAIT.
// - run_mode is sampled only in WAIT and in final states.
// - step_q<=step every cycle. A step rise outside WAIT is ignored, not queued.
// - Invariant: at most one of {pcbus,drlbus,rbus,acbus,membus} is asserted per cycle; drhbus and trbus are only ever asserted together.
// - Invariant: read and write are never asserted together.
// - Latency (cycles incl. FETCH1-3+DEC): NOP/MVAC/MOVR/ALU 5, LDAC/STAC 9, JUMP/taken jump 7, untaken jump 6.
// TESTING
// - rst=1 2 cycles, run_mode=1 -> state_code=0 and all controls 0; then 1,2,3,38 in consecutive cycles.
// - run_mode=1, ir=8'h01 -> states 1,2,3,38,5,6,7,8,9,1. instr_done only in state 9. LDAC5 shows drlbus=acload=1.
// - ir=8'h06: z=1 -> 20,21,22 with pcload in 22. z=0 -> 23,24 with pcinc both, then FETCH1.
// - run_mode=0, step held high 5 cycles -> one instruction executes, then WAIT. Second rise -> next instruction starts.
// - ir=8'h09 -> SUB1: rbus,acload,zload, alu_op=001. ir=8'h35 -> NOP1, all controls 0.
// - rst pulsed during STAC4 -> WAIT next cycle, write never asserted. Bus-exclusivity assertion holds across a random-opcode run.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - hardwired fetch/decode/execute control unit for the 8-bit CPU
//
// Purpose: Moore FSM that sequences the datapath one state per clock. It provides
//          free-run or single-step operation. All controls decode from the state
//          register only.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   ir[IR_W-1:0]           instruction register (opcode ir[3:0], legal only if upper bits are 0)
//   z                      datapath zero flag
//   run_mode, step         1=free-run / 0=single-step; step is a level, edge-detected here
//   read, write            memory strobes
//   arload..zload          register load/increment controls
//   pcbus..busmem          bus drivers
//   alu_op[2:0]            ALU function (000 outside ALU states)
//   state_code[ST_W-1:0]   current state, for display
//   instr_done             high in the last state of every instruction
module cpu_ctrl_fsm #(
  parameter int IR_W = 8,
  parameter int ST_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IR_W-1:0] ir,
  input  logic            z,
  input  logic            run_mode,
  input  logic            step,
  output logic            read,
  output logic            write,
  output logic            arload,
  output logic            arinc,
  output logic            pcinc,
  output logic            pcload,
  output logic            drload,
  output logic            trload,
  output logic            irload,
  output logic            rload,
  output logic            acload,
  output logic            zload,
  output logic            pcbus,
  output logic            drhbus,
  output logic            drlbus,
  output logic            trbus,
  output logic            rbus,
  output logic            acbus,
  output logic            membus,
  output logic            busmem,
  output logic [2:0]      alu_op,
  output logic [ST_W-1:0] state_code,
  output logic            instr_done
);

  localparam logic [ST_W-1:0] S_WAIT   = ST_W'(0);
  localparam logic [ST_W-1:0] S_FETCH1 = ST_W'(1);
  localparam logic [ST_W-1:0] S_FETCH2 = ST_W'(2);
  localparam logic [ST_W-1:0] S_FETCH3 = ST_W'(3);
  localparam logic [ST_W-1:0] S_NOP1   = ST_W'(4);
  localparam logic [ST_W-1:0] S_LDAC1  = ST_W'(5);
  localparam logic [ST_W-1:0] S_LDAC2  = ST_W'(6);
  localparam logic [ST_W-1:0] S_LDAC3  = ST_W'(7);
  localparam logic [ST_W-1:0] S_LDAC4  = ST_W'(8);
  localparam logic [ST_W-1:0] S_LDAC5  = ST_W'(9);
  localparam logic [ST_W-1:0] S_STAC1  = ST_W'(10);
  localparam logic [ST_W-1:0] S_STAC2  = ST_W'(11);
  localparam logic [ST_W-1:0] S_STAC3  = ST_W'(12);
  localparam logic [ST_W-1:0] S_STAC4  = ST_W'(13);
  localparam logic [ST_W-1:0] S_STAC5  = ST_W'(14);
  localparam logic [ST_W-1:0] S_MVAC1  = ST_W'(15);
  localparam logic [ST_W-1:0] S_MOVR1  = ST_W'(16);
  localparam logic [ST_W-1:0] S_JUMP1  = ST_W'(17);
  localparam logic [ST_W-1:0] S_JUMP2  = ST_W'(18);
  localparam logic [ST_W-1:0] S_JUMP3  = ST_W'(19);
  localparam logic [ST_W-1:0] S_JMPZY1 = ST_W'(20);
  localparam logic [ST_W-1:0] S_JMPZY2 = ST_W'(21);
  localparam logic [ST_W-1:0] S_JMPZY3 = ST_W'(22);
  localparam logic [ST_W-1:0] S_JMPZN1 = ST_W'(23);
  localparam logic [ST_W-1:0] S_JMPZN2 = ST_W'(24);
  localparam logic [ST_W-1:0] S_JPNZY1 = ST_W'(25);
  localparam logic [ST_W-1:0] S_JPNZY2 = ST_W'(26);
  localparam logic [ST_W-1:0] S_JPNZY3 = ST_W'(27);
  localparam logic [ST_W-1:0] S_JPNZN1 = ST_W'(28);
  localparam logic [ST_W-1:0] S_JPNZN2 = ST_W'(29);
  localparam logic [ST_W-1:0] S_ADD1   = ST_W'(30);
  localparam logic [ST_W-1:0] S_SUB1   = ST_W'(31);
  localparam logic [ST_W-1:0] S_INAC1  = ST_W'(32);
  localparam logic [ST_W-1:0] S_CLAC1  = ST_W'(33);
  localparam logic [ST_W-1:0] S_AND1   = ST_W'(34);
  localparam logic [ST_W-1:0] S_OR1    = ST_W'(35);
  localparam logic [ST_W-1:0] S_XOR1   = ST_W'(36);
  localparam logic [ST_W-1:0] S_NOT1   = ST_W'(37);
  localparam logic [ST_W-1:0] S_DEC    = ST_W'(38);

  logic [ST_W-1:0] r_state;
  logic            r_step_q;
  logic [ST_W-1:0] w_next;
  logic            w_step_rise;
  logic            w_legal_op;
  logic [ST_W-1:0] w_after_instr;

  assign w_step_rise   = step & ~r_step_q;
  assign w_legal_op    = (ir[IR_W-1:4] == '0);
  // run_mode is only looked at here (final states) and in WAIT
  assign w_after_instr = run_mode ? S_FETCH1 : S_WAIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_WAIT;
      r_step_q <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_step_q <= step;
    end
  end

  always_comb begin
    w_next = S_WAIT;
    case (r_state)
      S_WAIT:   w_next = (run_mode || w_step_rise) ? S_FETCH1 : S_WAIT;
      S_FETCH1: w_next = S_FETCH2;
      S_FETCH2: w_next = S_FETCH3;
      S_FETCH3: w_next = S_DEC;
      S_DEC: begin
        if (!w_legal_op) begin
          w_next = S_NOP1;
        end else begin
          case (ir[3:0])
            4'h0:    w_next = S_NOP1;
            4'h1:    w_next = S_LDAC1;
            4'h2:    w_next = S_STAC1;
            4'h3:    w_next = S_MVAC1;
            4'h4:    w_next = S_MOVR1;
            4'h5:    w_next = S_JUMP1;
            4'h6:    w_next = z ? S_JMPZY1 : S_JMPZN1;
            4'h7:    w_next = z ? S_JPNZN1 : S_JPNZY1;
            4'h8:    w_next = S_ADD1;
            4'h9:    w_next = S_SUB1;
            4'hA:    w_next = S_INAC1;
            4'hB:    w_next = S_CLAC1;
            4'hC:    w_next = S_AND1;
            4'hD:    w_next = S_OR1;
            4'hE:    w_next = S_XOR1;
            default: w_next = S_NOT1;
          endcase
        end
      end
      S_LDAC1:  w_next = S_LDAC2;
      S_LDAC2:  w_next = S_LDAC3;
      S_LDAC3:  w_next = S_LDAC4;
      S_LDAC4:  w_next = S_LDAC5;
      S_STAC1:  w_next = S_STAC2;
      S_STAC2:  w_next = S_STAC3;
      S_STAC3:  w_next = S_STAC4;
      S_STAC4:  w_next = S_STAC5;
      S_JUMP1:  w_next = S_JUMP2;
      S_JUMP2:  w_next = S_JUMP3;
      S_JMPZY1: w_next = S_JMPZY2;
      S_JMPZY2: w_next = S_JMPZY3;
      S_JMPZN1: w_next = S_JMPZN2;
      S_JPNZY1: w_next = S_JPNZY2;
      S_JPNZY2: w_next = S_JPNZY3;
      S_JPNZN1: w_next = S_JPNZN2;
      S_NOP1, S_LDAC5, S_STAC5, S_MVAC1, S_MOVR1, S_JUMP3,
      S_JMPZY3, S_JMPZN2, S_JPNZY3, S_JPNZN2,
      S_ADD1, S_SUB1, S_INAC1, S_CLAC1, S_AND1, S_OR1, S_XOR1, S_NOT1:
                w_next = w_after_instr;
      default:  w_next = S_WAIT;  // illegal codes recover to WAIT
    endcase
  end

  assign state_code = r_state;

  always_comb begin
    read = 1'b0;   write = 1'b0;  arload = 1'b0; arinc = 1'b0;
    pcinc = 1'b0;  pcload = 1'b0; drload = 1'b0; trload = 1'b0;
    irload = 1'b0; rload = 1'b0;  acload = 1'b0; zload = 1'b0;
    pcbus = 1'b0;  drhbus = 1'b0; drlbus = 1'b0; trbus = 1'b0;
    rbus = 1'b0;   acbus = 1'b0;  membus = 1'b0; busmem = 1'b0;
    alu_op = 3'b000;
    instr_done = 1'b0;
    case (r_state)
      S_FETCH1: begin pcbus = 1'b1; arload = 1'b1; end
      S_FETCH2: begin read = 1'b1; membus = 1'b1; drload = 1'b1; pcinc = 1'b1; end
      S_FETCH3: begin irload = 1'b1; pcbus = 1'b1; arload = 1'b1; end
      S_NOP1:   instr_done = 1'b1;
      S_LDAC1, S_STAC1: begin
        read = 1'b1; membus = 1'b1; drload = 1'b1; pcinc = 1'b1; arinc = 1'b1;
      end
      S_LDAC2, S_STAC2: begin
        read = 1'b1; membus = 1'b1; drload = 1'b1; trload = 1'b1; pcinc = 1'b1;
      end
      S_LDAC3, S_STAC3: begin drhbus = 1'b1; trbus = 1'b1; arload = 1'b1; end
      S_LDAC4:  begin read = 1'b1; membus = 1'b1; drload = 1'b1; end
      S_LDAC5:  begin drlbus = 1'b1; acload = 1'b1; instr_done = 1'b1; end
      S_STAC4:  begin acbus = 1'b1; drload = 1'b1; end
      S_STAC5:  begin drlbus = 1'b1; busmem = 1'b1; write = 1'b1; instr_done = 1'b1; end
      S_MVAC1:  begin acbus = 1'b1; rload = 1'b1; instr_done = 1'b1; end
      S_MOVR1:  begin rbus = 1'b1; acload = 1'b1; instr_done = 1'b1; end
      S_JUMP1, S_JMPZY1, S_JPNZY1: begin
        read = 1'b1; membus = 1'b1; drload = 1'b1; arinc = 1'b1;
      end
      S_JUMP2, S_JMPZY2, S_JPNZY2: begin
        read = 1'b1; membus = 1'b1; drload = 1'b1; trload = 1'b1;
      end
      S_JUMP3, S_JMPZY3, S_JPNZY3: begin
        drhbus = 1'b1; trbus = 1'b1; pcload = 1'b1; instr_done = 1'b1;
      end
      // untaken branch: step PC over the 2-byte target address
      S_JMPZN1, S_JPNZN1: pcinc = 1'b1;
      S_JMPZN2, S_JPNZN2: begin pcinc = 1'b1; instr_done = 1'b1; end
      S_ADD1, S_SUB1, S_AND1, S_OR1, S_XOR1: begin
        rbus = 1'b1; acload = 1'b1; zload = 1'b1; instr_done = 1'b1;
        alu_op = 3'(r_state - S_ADD1);
      end
      // single-operand ALU ops take nothing from the bus
      S_INAC1, S_CLAC1, S_NOT1: begin
        acload = 1'b1; zload = 1'b1; instr_done = 1'b1;
        alu_op = 3'(r_state - S_ADD1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - directed vector bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst, z, run_mode, step;
  logic [7:0] ir;
  logic       read, write, arload, arinc, pcinc, pcload, drload, trload, irload;
  logic       rload, acload, zload, pcbus, drhbus, drlbus, trbus, rbus, acbus;
  logic       membus, busmem, instr_done;
  logic [2:0] alu_op;
  logic [5:0] state_code;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.IR_W(8), .ST_W(6)) dut (
    .clk(clk), .rst(rst), .ir(ir), .z(z), .run_mode(run_mode), .step(step),
    .read(read), .write(write), .arload(arload), .arinc(arinc), .pcinc(pcinc),
    .pcload(pcload), .drload(drload), .trload(trload), .irload(irload),
    .rload(rload), .acload(acload), .zload(zload), .pcbus(pcbus),
    .drhbus(drhbus), .drlbus(drlbus), .trbus(trbus), .rbus(rbus),
    .acbus(acbus), .membus(membus), .busmem(busmem), .alu_op(alu_op),
    .state_code(state_code), .instr_done(instr_done)
  );

  // packed view of all controls, MSB first
  logic [23:0] ctl;
  assign ctl = {read, write, arload, arinc, pcinc, pcload, drload, trload, irload,
                rload, acload, zload, pcbus, drhbus, drlbus, trbus, rbus, acbus,
                membus, busmem, alu_op, instr_done};

  localparam logic [23:0] RD = 24'd1 << 23, WR = 24'd1 << 22, ARL = 24'd1 << 21;
  localparam logic [23:0] ARI = 24'd1 << 20, PCI = 24'd1 << 19, PCL = 24'd1 << 18;
  localparam logic [23:0] DRL = 24'd1 << 17, TRL = 24'd1 << 16, IRL = 24'd1 << 15;
  localparam logic [23:0] RL = 24'd1 << 14, ACL = 24'd1 << 13, ZL = 24'd1 << 12;
  localparam logic [23:0] PCB = 24'd1 << 11, DRHB = 24'd1 << 10, DRLB = 24'd1 << 9;
  localparam logic [23:0] TRB = 24'd1 << 8, RB = 24'd1 << 7, ACB = 24'd1 << 6;
  localparam logic [23:0] MEMB = 24'd1 << 5, BUSM = 24'd1 << 4, DONE = 24'd1;
  localparam logic [23:0] F1 = PCB | ARL;
  localparam logic [23:0] F2 = RD | MEMB | DRL | PCI;
  localparam logic [23:0] F3 = IRL | PCB | ARL;

  function automatic logic [23:0] alu(input int n);
    return 24'(n) << 1;
  endfunction

  typedef struct {
    logic       rst;
    logic       run;
    logic       stp;
    logic [7:0] ir;
    logic       z;
    logic [5:0] st;
    logic [23:0] ctl;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   viol = 0;
  int   done_cnt = 0;
  logic wr_seen = 1'b0;
  logic watch_wr = 1'b0;

  task automatic add(input logic r, input logic rn, input logic s, input logic [7:0] i,
                     input logic zz, input int st, input logic [23:0] c);
    vec_t v;
    v.rst = r; v.run = rn; v.stp = s; v.ir = i; v.z = zz; v.st = 6'(st); v.ctl = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // invariants on every cycle
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (!$onehot0({pcbus, drlbus, rbus, acbus, membus})) viol++;
      if (drhbus !== trbus) viol++;
      if (read && write) viol++;
      if (state_code > 6'd38) viol++;
      if (instr_done) done_cnt++;
    end
    if (watch_wr && write) wr_seen = 1'b1;
  end

  initial begin
    rst = 1'b1; run_mode = 1'b1; step = 1'b0; ir = 8'h01; z = 1'b0;

    add(1,1,0,8'h01,0, 0, 0);
    add(1,1,0,8'h01,0, 0, 0);
    // LDAC
    add(0,1,0,8'h01,0, 1, F1);
    add(0,1,0,8'h01,0, 2, F2);
    add(0,1,0,8'h01,0, 3, F3);
    add(0,1,0,8'h01,0, 38, 0);
    add(0,1,0,8'h01,0, 5, RD|MEMB|DRL|PCI|ARI);
    add(0,1,0,8'h01,0, 6, RD|MEMB|DRL|TRL|PCI);
    add(0,1,0,8'h01,0, 7, DRHB|TRB|ARL);
    add(0,1,0,8'h01,0, 8, RD|MEMB|DRL);
    add(0,1,0,8'h01,0, 9, DRLB|ACL|DONE);
    add(0,1,0,8'h01,0, 1, F1);
    // JMPZ taken
    add(0,1,0,8'h06,1, 2, F2);
    add(0,1,0,8'h06,1, 3, F3);
    add(0,1,0,8'h06,1, 38, 0);
    add(0,1,0,8'h06,1, 20, RD|MEMB|DRL|ARI);
    add(0,1,0,8'h06,1, 21, RD|MEMB|DRL|TRL);
    add(0,1,0,8'h06,1, 22, DRHB|TRB|PCL|DONE);
    add(0,1,0,8'h06,1, 1, F1);
    // JMPZ not taken
    add(0,1,0,8'h06,0, 2, F2);
    add(0,1,0,8'h06,0, 3, F3);
    add(0,1,0,8'h06,0, 38, 0);
    add(0,1,0,8'h06,0, 23, PCI);
    add(0,1,0,8'h06,0, 24, PCI|DONE);
    add(0,1,0,8'h06,0, 1, F1);
    // JPNZ taken (z=0)
    add(0,1,0,8'h07,0, 2, F2);
    add(0,1,0,8'h07,0, 3, F3);
    add(0,1,0,8'h07,0, 38, 0);
    add(0,1,0,8'h07,0, 25, RD|MEMB|DRL|ARI);
    add(0,1,0,8'h07,0, 26, RD|MEMB|DRL|TRL);
    add(0,1,0,8'h07,0, 27, DRHB|TRB|PCL|DONE);
    add(0,1,0,8'h07,0, 1, F1);
    // SUB
    add(0,1,0,8'h09,0, 2, F2);
    add(0,1,0,8'h09,0, 3, F3);
    add(0,1,0,8'h09,0, 38, 0);
    add(0,1,0,8'h09,0, 31, RB|ACL|ZL|alu(1)|DONE);
    add(0,1,0,8'h09,0, 1, F1);
    // illegal high nibble -> NOP
    add(0,1,0,8'h35,0, 2, F2);
    add(0,1,0,8'h35,0, 3, F3);
    add(0,1,0,8'h35,0, 38, 0);
    add(0,1,0,8'h35,0, 4, DONE);
    add(0,1,0,8'h35,0, 1, F1);
    // CLAC, NOT (no bus)
    add(0,1,0,8'h0B,0, 2, F2);
    add(0,1,0,8'h0B,0, 3, F3);
    add(0,1,0,8'h0B,0, 38, 0);
    add(0,1,0,8'h0B,0, 33, ACL|ZL|alu(3)|DONE);
    add(0,1,0,8'h0F,0, 1, F1);
    add(0,1,0,8'h0F,0, 2, F2);
    add(0,1,0,8'h0F,0, 3, F3);
    add(0,1,0,8'h0F,0, 38, 0);
    add(0,1,0,8'h0F,0, 37, ACL|ZL|alu(7)|DONE);
    // STAC
    add(0,1,0,8'h02,0, 1, F1);
    add(0,1,0,8'h02,0, 2, F2);
    add(0,1,0,8'h02,0, 3, F3);
    add(0,1,0,8'h02,0, 38, 0);
    add(0,1,0,8'h02,0, 10, RD|MEMB|DRL|PCI|ARI);
    add(0,1,0,8'h02,0, 11, RD|MEMB|DRL|TRL|PCI);
    add(0,1,0,8'h02,0, 12, DRHB|TRB|ARL);
    add(0,1,0,8'h02,0, 13, ACB|DRL);
    add(0,1,0,8'h02,0, 14, DRLB|BUSM|WR|DONE);
    // MOVR, then single-step mode drops back to WAIT
    add(0,1,0,8'h04,0, 1, F1);
    add(0,1,0,8'h04,0, 2, F2);
    add(0,1,0,8'h04,0, 3, F3);
    add(0,1,0,8'h04,0, 38, 0);
    add(0,1,0,8'h04,0, 16, RB|ACL|DONE);
    add(0,0,0,8'h04,0, 0, 0);
    add(0,0,0,8'h04,0, 0, 0);

    foreach (tbl[k]) begin
      rst = tbl[k].rst; run_mode = tbl[k].run; step = tbl[k].stp;
      ir = tbl[k].ir; z = tbl[k].z;
      tick();
      chk($sformatf("vec%0d_state", k), 32'(state_code), 32'(tbl[k].st));
      chk($sformatf("vec%0d_ctl", k), 32'(ctl), 32'(tbl[k].ctl));
    end

    // single-step: held step gives exactly one instruction (MVAC)
    ir = 8'h03; step = 1'b1;
    tick(); chk("step_f1", 32'(state_code), 1);
    tick(); chk("step_f2", 32'(state_code), 2);
    tick(); chk("step_f3", 32'(state_code), 3);
    tick(); chk("step_dec", 32'(state_code), 38);
    tick(); chk("step_mvac", 32'(state_code), 15);
    chk("step_mvac_ctl", 32'(ctl), 32'(ACB|RL|DONE));
    tick(); chk("step_wait1", 32'(state_code), 0);
    tick(); chk("step_wait2", 32'(state_code), 0);
    step = 1'b0;
    tick(); chk("step_low", 32'(state_code), 0);
    step = 1'b1;
    tick(); chk("step_rise2", 32'(state_code), 1);
    // rise during FETCH2 must not be remembered
    step = 1'b0;
    tick(); chk("step_mid_f2", 32'(state_code), 2);
    step = 1'b1;
    tick(); tick(); tick();
    chk("step_mid_mvac", 32'(state_code), 15);
    tick(); chk("step_noqueue1", 32'(state_code), 0);
    tick(); chk("step_noqueue2", 32'(state_code), 0);

    // reset in STAC4 aborts before the write
    step = 1'b0; run_mode = 1'b1; ir = 8'h02; rst = 1'b1;
    tick(); rst = 1'b0; watch_wr = 1'b1;
    begin
      int cyc = 0;
      while (state_code !== 6'd13 && cyc < 30) begin tick(); cyc++; end
      chk("reach_stac4", 32'(state_code), 13);
    end
    rst = 1'b1;
    tick();
    chk("rst_stac4_state", 32'(state_code), 0);
    chk("rst_stac4_ctl", 32'(ctl), 0);
    rst = 1'b0; run_mode = 1'b0;
    tick(); tick();
    watch_wr = 1'b0;
    chk("rst_stac4_nowrite", 32'(wr_seen), 0);

    // random opcode run, invariants watched every cycle
    viol = 0; done_cnt = 0; run_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      ir = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      z = 1'($urandom_range(0, 1));
      tick();
    end
    chk("invariant_violations", 32'(viol), 0);
    chk("random_progress", 32'(done_cnt > 300), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
